// File: rtl/pong_pkg.sv
// Shared types and default constants for the square-ball game.
package pong_pkg;

    // Round sequencer states; encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        SCORED    = 3'd3,
        GAME_OVER = 3'd4
    } pong_state_e;

    // Playfield geometry shared with the VGA top level.
    localparam int CENTER_X_DEF     = 270;
    localparam int LEFT_GOAL_DEF    = 160;
    localparam int RIGHT_GOAL_DEF   = 430;
    localparam int SQUARE_DIM       = 50;

    // Round pacing defaults.
    localparam int SPEED_SHIFT_DEF  = 6;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int WIN_SCORE_DEF    = 9;

    localparam int X_W     = 10;
    localparam int SCORE_W = 8;

endpackage

// File: rtl/pong_round_ctrl_if.sv
// Frame-rate control and status bundle between the round sequencer and the
// video/game logic that consumes ball position and scores.
interface pong_round_ctrl_if;
    import pong_pkg::*;

    logic               screenEnd;
    logic               startGame;
    logic               player;
    logic [7:0]         moveSpeed;
    logic [X_W-1:0]     squareX;
    logic [SCORE_W-1:0] leftScore;
    logic [SCORE_W-1:0] rightScore;
    logic               scorePulse;
    logic               gameOver;
    logic               winner;
    logic [2:0]         state;

    // Video/game side: supplies the frame tick and controls, reads results.
    modport master (
        output screenEnd, startGame, player, moveSpeed,
        input  squareX, leftScore, rightScore, scorePulse, gameOver, winner, state
    );

    // Round sequencer side.
    modport slave (
        input  screenEnd, startGame, player, moveSpeed,
        output squareX, leftScore, rightScore, scorePulse, gameOver, winner, state
    );

endinterface

// File: rtl/pong_round_ctrl_frame_timer.sv
// Loadable frame down-counter; reports done on a tick where the count is zero.
module frame_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    // Load takes priority; otherwise count down once per enabled tick, stopping at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (tick_i) begin
            if (load_i) begin
                count_q <= load_val_i;
            end else if (en_i && (count_q != '0)) begin
                count_q <= count_q - W'(1);
            end
        end
    end

    assign done_o = tick_i & en_i & (count_q == '0);

endmodule

// File: rtl/pong_round_ctrl.sv
// Round sequencer: owns ball X, both scores and the serve/play/score/game-over
// flow, advancing once per video frame on the end-of-frame pulse.
module pong_round_ctrl
    import pong_pkg::*;
#(
    parameter int CENTER_X     = CENTER_X_DEF,
    parameter int LEFT_GOAL    = LEFT_GOAL_DEF,
    parameter int RIGHT_GOAL   = RIGHT_GOAL_DEF,
    parameter int SPEED_SHIFT  = SPEED_SHIFT_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int WIN_SCORE    = WIN_SCORE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    pong_round_ctrl_if.slave bus
);

    localparam int TW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [TW-1:0]      SERVE_LOAD = TW'(SERVE_FRAMES - 1);
    localparam logic [X_W-1:0]     CENTER     = X_W'(CENTER_X);
    localparam logic [X_W-1:0]     LGOAL      = X_W'(LEFT_GOAL);
    localparam logic [X_W-1:0]     RGOAL      = X_W'(RIGHT_GOAL);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    pong_state_e        state_q;
    logic [X_W-1:0]     x_q;
    logic [SCORE_W-1:0] left_q;
    logic [SCORE_W-1:0] right_q;
    logic               pulse_q;
    logic               over_q;
    logic               winner_q;

    logic [X_W-1:0]     step_d;
    logic [X_W-1:0]     next_x_d;
    logic               goal_left_d;
    logic               goal_right_d;
    logic               timer_load;
    logic               timer_done;

    // Candidate next ball position and goal decisions for the current frame.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        step_d       = '0;
        next_x_d     = x_q;
        goal_left_d  = 1'b0;
        goal_right_d = 1'b0;
        step_d       = X_W'(bus.moveSpeed >> SPEED_SHIFT);
        next_x_d     = bus.player ? (x_q - step_d) : (x_q + step_d);
        goal_left_d  = (next_x_d < LGOAL);
        goal_right_d = (next_x_d > RGOAL);
    end

    // The serve counter is reloaded when a serve starts (from IDLE or after a non-final point).
    assign timer_load = bus.screenEnd &
                        (((state_q == IDLE) && bus.startGame) ||
                         ((state_q == SCORED) && (left_q != WIN) && (right_q != WIN)));

    frame_timer #(
        .W (TW)
    ) u_serve_timer (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (bus.screenEnd),
        .load_i     (timer_load),
        .load_val_i (SERVE_LOAD),
        .en_i       (state_q == SERVE),
        .done_o     (timer_done)
    );

    // Round FSM with registered outputs; everything except scorePulse moves only on frame ticks.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            state_q  <= IDLE;
            x_q      <= CENTER;
            left_q   <= '0;
            right_q  <= '0;
            pulse_q  <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (bus.screenEnd) begin
                case (state_q)
                    IDLE: begin
                        x_q <= CENTER;
                        if (bus.startGame) state_q <= SERVE;
                    end
                    SERVE: begin
                        x_q <= CENTER;
                        if (timer_done) state_q <= PLAY;
                    end
                    PLAY: begin
                        if (bus.startGame) begin
                            if (goal_left_d) begin
                                right_q <= right_q + SCORE_W'(1);
                                x_q     <= CENTER;
                                pulse_q <= 1'b1;
                                state_q <= SCORED;
                            end else if (goal_right_d) begin
                                left_q  <= left_q + SCORE_W'(1);
                                x_q     <= CENTER;
                                pulse_q <= 1'b1;
                                state_q <= SCORED;
                            end else begin
                                x_q <= next_x_d;
                            end
                        end
                    end
                    SCORED: begin
                        if (left_q == WIN) begin
                            winner_q <= 1'b1;
                            over_q   <= 1'b1;
                            state_q  <= GAME_OVER;
                        end else if (right_q == WIN) begin
                            winner_q <= 1'b0;
                            over_q   <= 1'b1;
                            state_q  <= GAME_OVER;
                        end else begin
                            state_q <= SERVE;
                        end
                    end
                    GAME_OVER: begin
                        if (!bus.startGame) begin
                            left_q   <= '0;
                            right_q  <= '0;
                            over_q   <= 1'b0;
                            winner_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.squareX    = x_q;
    assign bus.leftScore  = left_q;
    assign bus.rightScore = right_q;
    assign bus.scorePulse = pulse_q;
    assign bus.gameOver   = over_q;
    assign bus.winner     = winner_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_pong_round_ctrl.sv
// Directed bench for the round sequencer: serve, movement, both goals,
// pause, tick-only sampling, game over and reset during play.
module tb_pong_round_ctrl;
    import pong_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pong_round_ctrl_if bus ();

    pong_round_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // One frame tick: screenEnd high for exactly one rising edge; returns on the next falling edge.
    task automatic tick();
        @(negedge clk);
        bus.screenEnd = 1'b1;
        @(negedge clk);
        bus.screenEnd = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        bus.screenEnd = 1'b0; bus.startGame = 1'b0; bus.player = 1'b0; bus.moveSpeed = 8'd0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", bus.state); end
        checks++; if (bus.squareX !== 10'd270) begin errors++; $display("FAIL rst_x got %0d want 270", bus.squareX); end
        checks++; if (bus.leftScore !== 8'd0) begin errors++; $display("FAIL rst_left got %0d want 0", bus.leftScore); end
        checks++; if (bus.rightScore !== 8'd0) begin errors++; $display("FAIL rst_right got %0d want 0", bus.rightScore); end
        checks++; if (bus.scorePulse !== 1'b0) begin errors++; $display("FAIL rst_pulse got %0b want 0", bus.scorePulse); end
        checks++; if (bus.gameOver !== 1'b0) begin errors++; $display("FAIL rst_over got %0b want 0", bus.gameOver); end
        checks++; if (bus.winner !== 1'b0) begin errors++; $display("FAIL rst_winner got %0b want 0", bus.winner); end
    endtask

    task automatic test_serve_right();
        bus.startGame = 1'b1; bus.player = 1'b0; bus.moveSpeed = 8'd192;
        tick();
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL serve_enter got %0d want 1", bus.state); end
        checks++; if (bus.squareX !== 10'd270) begin errors++; $display("FAIL serve_x got %0d want 270", bus.squareX); end
        ticks(59);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL serve_59 got %0d want 1", bus.state); end
        tick();
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL serve_60 got %0d want 2", bus.state); end
        checks++; if (bus.squareX !== 10'd270) begin errors++; $display("FAIL play_start_x got %0d want 270", bus.squareX); end
        // Latency: unchanged while screenEnd is merely asserted, updated just after the sampling edge.
        @(negedge clk);
        bus.screenEnd = 1'b1;
        checks++; if (bus.squareX !== 10'd270) begin errors++; $display("FAIL lat_before got %0d want 270", bus.squareX); end
        @(posedge clk); #1;
        checks++; if (bus.squareX !== 10'd273) begin errors++; $display("FAIL lat_after got %0d want 273", bus.squareX); end
        @(negedge clk);
        bus.screenEnd = 1'b0;
        tick();
        checks++; if (bus.squareX !== 10'd276) begin errors++; $display("FAIL move_276 got %0d want 276", bus.squareX); end
    endtask

    task automatic test_left_goal();
        ticks(51);
        checks++; if (bus.squareX !== 10'd429) begin errors++; $display("FAIL pre_goal_x got %0d want 429", bus.squareX); end
        checks++; if (bus.leftScore !== 8'd0) begin errors++; $display("FAIL pre_goal_left got %0d want 0", bus.leftScore); end
        tick();
        checks++; if (bus.leftScore !== 8'd1) begin errors++; $display("FAIL lgoal_left got %0d want 1", bus.leftScore); end
        checks++; if (bus.squareX !== 10'd270) begin errors++; $display("FAIL lgoal_x got %0d want 270", bus.squareX); end
        checks++; if (bus.scorePulse !== 1'b1) begin errors++; $display("FAIL lgoal_pulse got %0b want 1", bus.scorePulse); end
        checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL lgoal_state got %0d want 3", bus.state); end
        @(negedge clk);
        checks++; if (bus.scorePulse !== 1'b0) begin errors++; $display("FAIL lgoal_pulse_end got %0b want 0", bus.scorePulse); end
        checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL scored_hold got %0d want 3", bus.state); end
        tick();
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL scored_to_serve got %0d want 1", bus.state); end
        // Exact landing on the right goal line is not a point.
        ticks(60);
        bus.moveSpeed = 8'd128;
        ticks(80);
        checks++; if (bus.squareX !== 10'd430) begin errors++; $display("FAIL edge_430_x got %0d want 430", bus.squareX); end
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL edge_430_state got %0d want 2", bus.state); end
        checks++; if (bus.leftScore !== 8'd1) begin errors++; $display("FAIL edge_430_left got %0d want 1", bus.leftScore); end
        tick();
        checks++; if (bus.leftScore !== 8'd2) begin errors++; $display("FAIL edge_432_left got %0d want 2", bus.leftScore); end
        checks++; if (bus.scorePulse !== 1'b1) begin errors++; $display("FAIL edge_432_pulse got %0b want 1", bus.scorePulse); end
    endtask

    task automatic test_right_goal();
        tick();
        ticks(60);
        bus.player = 1'b1; bus.moveSpeed = 8'd255;
        ticks(36);
        checks++; if (bus.squareX !== 10'd162) begin errors++; $display("FAIL rgoal_pre_x got %0d want 162", bus.squareX); end
        checks++; if (bus.rightScore !== 8'd0) begin errors++; $display("FAIL rgoal_pre got %0d want 0", bus.rightScore); end
        tick();
        checks++; if (bus.rightScore !== 8'd1) begin errors++; $display("FAIL rgoal_right got %0d want 1", bus.rightScore); end
        checks++; if (bus.leftScore !== 8'd2) begin errors++; $display("FAIL rgoal_left got %0d want 2", bus.leftScore); end
        checks++; if (bus.squareX !== 10'd270) begin errors++; $display("FAIL rgoal_x got %0d want 270", bus.squareX); end
        checks++; if (bus.scorePulse !== 1'b1) begin errors++; $display("FAIL rgoal_pulse got %0b want 1", bus.scorePulse); end
    endtask

    task automatic test_zero_step();
        tick();
        ticks(60);
        bus.moveSpeed = 8'd63;
        ticks(100);
        checks++; if (bus.squareX !== 10'd270) begin errors++; $display("FAIL step0_x got %0d want 270", bus.squareX); end
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL step0_state got %0d want 2", bus.state); end
    endtask

    task automatic test_pause();
        bus.moveSpeed = 8'd128; bus.player = 1'b0;
        tick();
        checks++; if (bus.squareX !== 10'd272) begin errors++; $display("FAIL pause_pre got %0d want 272", bus.squareX); end
        bus.startGame = 1'b0;
        ticks(10);
        checks++; if (bus.squareX !== 10'd272) begin errors++; $display("FAIL pause_x got %0d want 272", bus.squareX); end
        checks++; if ({bus.leftScore, bus.rightScore} !== {8'd2, 8'd1}) begin errors++; $display("FAIL pause_scores got %0d/%0d want 2/1", bus.leftScore, bus.rightScore); end
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL pause_state got %0d want 2", bus.state); end
        bus.startGame = 1'b1;
    endtask

    task automatic test_mid_frame();
        bus.player = 1'b1;
        repeat (3) @(negedge clk);
        bus.player = 1'b0;
        tick();
        checks++; if (bus.squareX !== 10'd274) begin errors++; $display("FAIL midframe_right got %0d want 274", bus.squareX); end
        bus.player = 1'b0;
        repeat (3) @(negedge clk);
        bus.player = 1'b1;
        tick();
        checks++; if (bus.squareX !== 10'd272) begin errors++; $display("FAIL midframe_left got %0d want 272", bus.squareX); end
        // Held screenEnd: three consecutive edges are three ticks.
        @(negedge clk);
        bus.screenEnd = 1'b1;
        repeat (3) @(negedge clk);
        bus.screenEnd = 1'b0;
        checks++; if (bus.squareX !== 10'd266) begin errors++; $display("FAIL held_tick got %0d want 266", bus.squareX); end
    endtask

    // Play rightward at step 3 until a point is awarded (bounded), then check the new left score.
    task automatic score_left_point(input int exp_left);
        bit seen;
        seen = 1'b0;
        bus.player = 1'b0; bus.moveSpeed = 8'd255; bus.startGame = 1'b1;
        for (int i = 0; i < 500 && !seen; i++) begin
            tick();
            if (bus.scorePulse === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL point_timeout got no pulse want pulse (left %0d)", exp_left); end
        checks++; if (bus.leftScore !== 8'(exp_left)) begin errors++; $display("FAIL point_left got %0d want %0d", bus.leftScore, exp_left); end
    endtask

    task automatic test_game_over();
        for (int s = 3; s <= 9; s++) score_left_point(s);
        checks++; if (bus.rightScore !== 8'd1) begin errors++; $display("FAIL go_right got %0d want 1", bus.rightScore); end
        checks++; if (bus.gameOver !== 1'b0) begin errors++; $display("FAIL go_early got %0b want 0", bus.gameOver); end
        tick();
        checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL go_state got %0d want 4", bus.state); end
        checks++; if (bus.gameOver !== 1'b1) begin errors++; $display("FAIL go_flag got %0b want 1", bus.gameOver); end
        checks++; if (bus.winner !== 1'b1) begin errors++; $display("FAIL go_winner got %0b want 1", bus.winner); end
        ticks(5);
        checks++; if ({bus.state, bus.gameOver, bus.winner} !== {3'd4, 1'b1, 1'b1}) begin errors++; $display("FAIL go_hold got %0d/%0b/%0b want 4/1/1", bus.state, bus.gameOver, bus.winner); end
        checks++; if ({bus.leftScore, bus.rightScore} !== {8'd9, 8'd1}) begin errors++; $display("FAIL go_scores got %0d/%0d want 9/1", bus.leftScore, bus.rightScore); end
        bus.startGame = 1'b0;
        tick();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL go_idle got %0d want 0", bus.state); end
        checks++; if ({bus.leftScore, bus.rightScore} !== 16'd0) begin errors++; $display("FAIL go_clear got %0d/%0d want 0/0", bus.leftScore, bus.rightScore); end
        checks++; if (bus.gameOver !== 1'b0) begin errors++; $display("FAIL go_over_clr got %0b want 0", bus.gameOver); end
    endtask

    task automatic test_reset_mid_play();
        bus.startGame = 1'b1; bus.player = 1'b0; bus.moveSpeed = 8'd192;
        tick();
        ticks(60);
        tick();
        checks++; if (bus.squareX !== 10'd273) begin errors++; $display("FAIL rmp_x got %0d want 273", bus.squareX); end
        ticks(52);
        checks++; if (bus.squareX !== 10'd429) begin errors++; $display("FAIL rmp_pre got %0d want 429", bus.squareX); end
        // Next tick would score; reset on the same edge must win.
        @(negedge clk);
        reset = 1'b0; bus.screenEnd = 1'b1;
        @(negedge clk);
        reset = 1'b1; bus.screenEnd = 1'b0;
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rmp_state got %0d want 0", bus.state); end
        checks++; if (bus.squareX !== 10'd270) begin errors++; $display("FAIL rmp_x_rst got %0d want 270", bus.squareX); end
        checks++; if ({bus.leftScore, bus.rightScore} !== 16'd0) begin errors++; $display("FAIL rmp_scores got %0d/%0d want 0/0", bus.leftScore, bus.rightScore); end
        checks++; if ({bus.scorePulse, bus.gameOver, bus.winner} !== 3'b000) begin errors++; $display("FAIL rmp_flags got %b want 000", {bus.scorePulse, bus.gameOver, bus.winner}); end
    endtask

    initial begin
        test_reset();
        test_serve_right();
        test_left_goal();
        test_right_goal();
        test_zero_step();
        test_pause();
        test_mid_frame();
        test_game_over();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
